network_multiq_host: RTL and testbench

NETWORK_MULTIQ_HOST -- requirements
Module: network_multiq_host

---
 rtl/network_multiq_host.sv | 145 ++++++++++++++
 tb/tb_network_multiq_host.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/network_multiq_host.sv
// Multi-queue host ingress: per-channel FIFOs, round-robin egress arbiter with
// optional dequeue masking, drop accounting and a rolling scramble key.
module network_multiq_host #(
  parameter int          PKT_W    = 512,
  parameter int          NUM_CH   = 4,
  parameter int          DEPTH    = 8,
  parameter logic [127:0] KEY_INIT = 128'h123456789ABCDEF0FEDCBA0987654321
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PKT_W-1:0]          in_data,
  input  logic                      in_valid,
  input  logic [$clog2(NUM_CH)-1:0] in_dest,
  output logic                      in_ready,
  output logic [PKT_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] out_chan,
  output logic                      route_error,
  output logic [15:0]               drop_count,
  output logic [127:0]              key_out,
  input  logic [63:0]               load_in,
  input  logic                      scramble_en
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and a stalled egress holds its payload.
  logic [PKT_W-1:0] r_mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0] r_wptr [NUM_CH];
  logic [PTR_W-1:0] r_rptr [NUM_CH];
  logic [CNT_W-1:0] r_cnt [NUM_CH];
  logic [CH_W-1:0]  r_last_grant;
  logic [CH_W-1:0]  r_out_chan;
  logic [PKT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_route_error;
  logic [15:0]      r_drop_count;
  logic [127:0]     r_key;

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_nonempty;
  logic [NUM_CH-1:0] w_push_vec;
  logic [NUM_CH-1:0] w_pop_vec;
  logic [CH_W-1:0]   w_grant;
  logic              w_accept;
  logic              w_drop;
  logic              w_free;
  logic              w_pop;
  logic [PKT_W-1:0]  w_head;
  logic [PKT_W-1:0]  w_mask;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_full[ch]     = (r_cnt[ch] == CNT_W'(DEPTH));
      w_nonempty[ch] = (r_cnt[ch] != '0);
    end
  end

  // Readiness uses the pre-pop count, so a full queue refuses even while draining.
  assign in_ready = !w_full[in_dest];
  assign w_accept = in_valid && in_ready;
  assign w_drop   = in_valid && !in_ready;
  assign w_free   = !r_out_valid || out_ready;
  assign w_pop    = w_free && (|w_nonempty);

  // Highest priority goes to the channel just after the previous grant.
  always_comb begin
    w_grant = r_last_grant;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (w_nonempty[CH_W'(int'(r_last_grant) + i)]) begin
        w_grant = CH_W'(int'(r_last_grant) + i);
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_push_vec[ch] = w_accept && (in_dest == CH_W'(ch));
      w_pop_vec[ch]  = w_pop && (w_grant == CH_W'(ch));
    end
  end

  assign w_head = r_mem[w_grant][r_rptr[w_grant]];
  assign w_mask = scramble_en ? PKT_W'(load_in) : '0;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[in_dest][r_wptr[in_dest]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_wptr[ch] <= '0;
        r_rptr[ch] <= '0;
        r_cnt[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_push_vec[ch]) r_wptr[ch] <= r_wptr[ch] + 1'b1;
        if (w_pop_vec[ch])  r_rptr[ch] <= r_rptr[ch] + 1'b1;
        r_cnt[ch] <= r_cnt[ch] + CNT_W'(w_push_vec[ch]) - CNT_W'(w_pop_vec[ch]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_chan    <= '0;
      r_last_grant  <= CH_W'(NUM_CH - 1);
      r_route_error <= 1'b0;
      r_drop_count  <= '0;
      r_key         <= KEY_INIT;
    end else begin
      r_route_error <= w_drop;
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_accept) begin
        r_key <= {r_key[123:0], r_key[127:124] ^ 4'(in_dest)};
      end
      if (w_pop) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_head ^ w_mask;
        r_out_chan   <= w_grant;
        r_last_grant <= w_grant;
      end else if (w_free) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_chan    = r_out_chan;
  assign route_error = r_route_error;
  assign drop_count  = r_drop_count;
  assign key_out     = r_key;
endmodule

// File: tb/tb_network_multiq_host.sv
// Directed bench for network_multiq_host: per-channel expected queues filled at
// push time and drained by an egress monitor, plus latency/drop/reset checks.
module tb_network_multiq_host;
  localparam int           PKT_W    = 512;
  localparam int           NUM_CH   = 4;
  localparam int           DEPTH    = 8;
  localparam logic [127:0] KEY_INIT = 128'h123456789ABCDEF0FEDCBA0987654321;
  localparam int           CH_W     = $clog2(NUM_CH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PKT_W-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic [CH_W-1:0]   in_dest = '0;
  logic              in_ready;
  logic [PKT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CH_W-1:0]   out_chan;
  logic              route_error;
  logic [15:0]       drop_count;
  logic [127:0]      key_out;
  logic [63:0]       load_in = '0;
  logic              scramble_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [PKT_W-1:0] exp_q [NUM_CH][$];
  logic [CH_W-1:0]  chan_q[$];
  logic [127:0]     exp_key = KEY_INIT;

  network_multiq_host #(
    .PKT_W(PKT_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .KEY_INIT(KEY_INIT)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_dest(in_dest), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .route_error(route_error), .drop_count(drop_count), .key_out(key_out),
    .load_in(load_in), .scramble_en(scramble_en)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [PKT_W-1:0] obs,
                     input logic [PKT_W-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [PKT_W-1:0] rand_pkt();
    logic [PKT_W-1:0] v;
    for (int i = 0; i < PKT_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int sb_size();
    int s = 0;
    for (int c = 0; c < NUM_CH; c++) s += exp_q[c].size();
    return s;
  endfunction

  task automatic flush_sb();
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    chan_q.delete();
    exp_key = KEY_INIT;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush_sb();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drives one packet for one cycle; scoreboard entry is recorded only if taken.
  task automatic push(input logic [CH_W-1:0] dest, input logic [PKT_W-1:0] data,
                      input logic exp_acc, input string tag);
    logic [PKT_W-1:0] mask;
    in_valid = 1'b1;
    in_dest  = dest;
    in_data  = data;
    @(negedge clk);
    chk(tag, in_ready, exp_acc);
    if (in_ready) begin
      mask = scramble_en ? PKT_W'(load_in) : '0;
      exp_q[dest].push_back(data ^ mask);
      exp_key = {exp_key[123:0], exp_key[127:124] ^ 4'(dest)};
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic done = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sb_size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Egress monitor: compares each consumed packet with its channel's queue.
  always @(negedge clk) begin
    logic [PKT_W-1:0] e;
    logic [CH_W-1:0]  ec;
    if (!rst && out_valid && out_ready) begin
      if (exp_q[out_chan].size() == 0) begin
        chk("unexpected_out", out_valid, 1'b0);
      end else begin
        e = exp_q[out_chan].pop_front();
        chk("out_data", out_data, e);
      end
      if (chan_q.size() > 0) begin
        ec = chan_q.pop_front();
        chk("rr_order", out_chan, ec);
      end
    end
  end

  initial begin
    logic [CH_W-1:0] order [4];
    do_reset();

    // Reset values
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_chan", out_chan, '0);
    chk("rst_route_error", route_error, 1'b0);
    chk("rst_drop_count", drop_count, 16'd0);
    chk("rst_key", key_out, KEY_INIT);
    chk("rst_in_ready", in_ready, 1'b1);

    // Single packet latency, channel and key rotation
    out_ready = 1'b1;
    push(2'd2, rand_pkt(), 1'b1, "single_acc");
    @(negedge clk);
    chk("lat_t1_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_t2_valid", out_valid, 1'b1);
    chk("lat_t2_chan", out_chan, 2'd2);
    chk("key_one", key_out, {KEY_INIT[123:0], 4'h3});
    drain("drain_single");

    // Fill channel 0 behind a stalled output, then overflow
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(2'd0, rand_pkt(), 1'b1, "fill_acc");
    push(2'd0, rand_pkt(), 1'b0, "full_refuse");
    @(negedge clk);
    chk("route_error_pulse", route_error, 1'b1);
    chk("drop_count_one", drop_count, 16'd1);
    chk("key_after_fill", key_out, exp_key);
    @(negedge clk);
    chk("route_error_clear", route_error, 1'b0);
    chk("stall_valid_held", out_valid, 1'b1);
    @(posedge clk);
    #1;
    // Pop and push the same full queue in one cycle: still refused
    out_ready = 1'b1;
    push(2'd0, rand_pkt(), 1'b0, "full_pop_refuse");
    @(negedge clk);
    chk("drop_count_two", drop_count, 16'd2);
    drain("drain_fill");

    // Round-robin: plug the output with channel 3, queue 3,1,0,2, release
    out_ready = 1'b0;
    push(2'd3, rand_pkt(), 1'b1, "plug_acc");
    order = '{2'd3, 2'd1, 2'd0, 2'd2};
    for (int i = 0; i < 4; i++) push(order[i], rand_pkt(), 1'b1, "rr_acc");
    chan_q.push_back(2'd3);
    for (int c = 0; c < 4; c++) chan_q.push_back(CH_W'(c));
    drain("drain_rr");
    chk("rr_order_consumed", 32'(chan_q.size()), 32'd0);

    // Dequeue masking
    scramble_en = 1'b1;
    load_in = 64'hFFFF_0000_FFFF_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      push(CH_W'($urandom_range(0, NUM_CH - 1)), rand_pkt(), 1'b1, "scr_acc");
    drain("drain_scramble");
    scramble_en = 1'b0;
    load_in = '0;

    // Drop counter saturation
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(2'd1, rand_pkt(), 1'b1, "sat_fill");
    in_valid = 1'b1;
    in_dest  = 2'd1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("drop_count_fffe", drop_count, 16'hFFFE);
    repeat (70000 - 65534) @(posedge clk);
    @(negedge clk);
    chk("drop_count_sat", drop_count, 16'hFFFF);
    chk("route_error_held", route_error, 1'b1);
    chk("sat_valid_held", out_valid, 1'b1);
    in_valid = 1'b0;

    // Asynchronous reset mid-operation
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, '0);
    chk("arst_drop_count", drop_count, 16'd0);
    chk("arst_key", key_out, KEY_INIT);
    flush_sb();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int d = 0; d < NUM_CH; d++) begin
      in_dest = CH_W'(d);
      #1;
      chk("arst_in_ready", in_ready, 1'b1);
    end
    @(negedge clk);
    chk("arst_queues_empty", out_valid, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(2'd1, rand_pkt(), 1'b1, "recover_acc");
    drain("drain_recover");
    chk("recover_key", key_out, exp_key);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
